// File: rtl/timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_ctrl_pkg
// Brief    : State encoding and defaults shared by the run-control sequencer.
// Revision : 1.0
// ============================================================================
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int DEF_ALARM_TICKS = 3;

endpackage
`default_nettype wire

// File: rtl/timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_ctrl_if
// Brief    : Button/strobe inputs and timer control outputs of timer_ctrl.
// Revision : 1.0
// ============================================================================
interface timer_ctrl_if;
    import timer_ctrl_pkg::*;

    logic   btn_start;
    logic   btn_pause;
    logic   btn_clear;
    logic   tick;
    logic   time_up;
    logic   timer_en;
    logic   timer_clr;
    logic   alarm;
    state_t state;
    logic   done;

    // master: board/debounce side and timer datapath; slave: the sequencer
    modport master (
        output btn_start, btn_pause, btn_clear, tick, time_up,
        input  timer_en, timer_clr, alarm, state, done
    );

    modport slave (
        input  btn_start, btn_pause, btn_clear, tick, time_up,
        output timer_en, timer_clr, alarm, state, done
    );

endinterface
`default_nettype wire

// File: rtl/timer_ctrl_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect
// Brief    : One-bit rising-edge detector; pulse is combinational from d.
// Revision : 1.0
// ============================================================================
module edge_detect (
    input  wire  clk,
    input  wire  rstn,
    input  wire  d,
    output logic pulse
);

    logic r_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q <= 1'b0;
        end else begin
            r_q <= d;
        end
    end

    assign pulse = d & ~r_q;

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timer_ctrl
// Brief    : Run-control FSM turning button events into timer enable/clear.
// Revision : 1.0
// ============================================================================
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int ALARM_TICKS = DEF_ALARM_TICKS,
    parameter int AW          = $clog2(ALARM_TICKS + 1)
) (
    input  wire          clk,
    input  wire          rstn,
    timer_ctrl_if.slave  bus
);

    localparam logic [AW-1:0] c_alarm_max = AW'(ALARM_TICKS);

    logic          w_ev_start;
    logic          w_ev_pause;
    logic          w_ev_clear;
    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_next_cnt;
    logic          w_next_clr;
    logic          r_timer_en;
    logic          r_timer_clr;
    logic          r_alarm;
    logic          r_done;

    edge_detect u_ed_start (.clk(clk), .rstn(rstn), .d(bus.btn_start), .pulse(w_ev_start));
    edge_detect u_ed_pause (.clk(clk), .rstn(rstn), .d(bus.btn_pause), .pulse(w_ev_pause));
    edge_detect u_ed_clear (.clk(clk), .rstn(rstn), .d(bus.btn_clear), .pulse(w_ev_clear));

    // Priority: clear > time_up > start > pause
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_clr   = 1'b0;
        if (w_ev_clear) begin
            w_next_state = ST_IDLE;
            w_next_clr   = 1'b1;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ev_start) begin
                        w_next_state = ST_RUN;
                        w_next_clr   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.time_up) begin
                        w_next_state = ST_DONE;
                        w_next_cnt   = '0;
                    end else if (w_ev_pause) begin
                        w_next_state = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_ev_start || w_ev_pause) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (w_ev_start) begin
                        w_next_state = ST_RUN;
                        w_next_clr   = 1'b1;
                        w_next_cnt   = '0;
                    end else if (bus.tick && (r_cnt != c_alarm_max)) begin
                        w_next_cnt = r_cnt + AW'(1);
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_timer_en  <= 1'b0;
            r_timer_clr <= 1'b0;
            r_alarm     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_timer_clr <= w_next_clr;
            r_timer_en  <= (w_next_state == ST_RUN);
            r_done      <= (w_next_state == ST_DONE);
            r_alarm     <= (w_next_state == ST_DONE) && (w_next_cnt < c_alarm_max);
        end
    end

    assign bus.state     = r_state;
    assign bus.timer_en  = r_timer_en;
    assign bus.timer_clr = r_timer_clr;
    assign bus.alarm     = r_alarm;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_ctrl
// Brief    : Directed and randomized checks of timer_ctrl against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_timer_ctrl;

    localparam int ALARM_TICKS = 3;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    timer_ctrl_if bus();

    timer_ctrl #(.ALARM_TICKS(ALARM_TICKS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: state as a number 0..3, ticks counted since DONE entry
    int m_st;
    int m_ticks;
    bit m_clr;
    bit m_ps, m_pp, m_pc;

    task automatic model_reset();
        m_st = 0; m_ticks = 0; m_clr = 0;
        m_ps = 0; m_pp = 0; m_pc = 0;
    endtask

    task automatic model_edge(input bit s, input bit p, input bit c, input bit t, input bit tu);
        bit es, ep, ec;
        es = s && !m_ps; ep = p && !m_pp; ec = c && !m_pc;
        m_ps = s; m_pp = p; m_pc = c;
        m_clr = 0;
        if (ec) begin
            m_st = 0; m_clr = 1; m_ticks = 0;
        end else if (m_st == 0) begin
            if (es) begin m_st = 1; m_clr = 1; end
        end else if (m_st == 1) begin
            if (tu) begin m_st = 3; m_ticks = 0; end
            else if (ep) m_st = 2;
        end else if (m_st == 2) begin
            if (es || ep) m_st = 1;
        end else begin
            if (es) begin m_st = 1; m_clr = 1; m_ticks = 0; end
            else if (t) m_ticks++;
        end
    endtask

    function automatic logic [5:0] model_vec();
        return {2'(m_st), (m_st == 1), m_clr, (m_st == 3) && (m_ticks < ALARM_TICKS), (m_st == 3)};
    endfunction

    function automatic logic [5:0] dut_vec();
        return {bus.state, bus.timer_en, bus.timer_clr, bus.alarm, bus.done};
    endfunction

    task automatic step(input bit s, input bit p, input bit c, input bit t, input bit tu);
        bus.btn_start = s; bus.btn_pause = p; bus.btn_clear = c;
        bus.tick = t; bus.time_up = tu;
        @(posedge clk);
        model_edge(s, p, c, t, tu);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.btn_start = 0; bus.btn_pause = 0; bus.btn_clear = 0;
        bus.tick = 0; bus.time_up = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dut_vec() !== 6'b0) begin
            bad++; $display("FAIL reset_outputs: got %b expected %b", dut_vec(), 6'b0);
        end
        rstn = 1'b1;
        step(0, 0, 0, 0, 0);
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL reset_idle: got %b expected %b", dut_vec(), model_vec());
        end
    endtask

    task automatic test_start_hold();
        int pulses;
        step(1, 0, 0, 0, 0);
        total++;
        if (bus.state !== 2'd1) begin bad++; $display("FAIL start_state: got %0d expected 1", bus.state); end
        total++;
        if (bus.timer_clr !== 1'b1) begin bad++; $display("FAIL start_clr: got %b expected 1", bus.timer_clr); end
        total++;
        if (bus.timer_en !== 1'b1) begin bad++; $display("FAIL start_en: got %b expected 1", bus.timer_en); end
        pulses = 0;
        repeat (100) begin
            step(1, 0, 0, 0, 0);
            if (bus.timer_clr) pulses++;
        end
        total++;
        if (pulses != 0 || bus.state !== 2'd1) begin
            bad++; $display("FAIL start_hold: got pulses=%0d state=%0d expected pulses=0 state=1", pulses, bus.state);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_pause_resume();
        step(0, 1, 0, 0, 0);
        total++;
        if ({bus.state, bus.timer_en, bus.timer_clr} !== {2'd2, 1'b0, 1'b0}) begin
            bad++; $display("FAIL pause: got st=%0d en=%b clr=%b expected st=2 en=0 clr=0", bus.state, bus.timer_en, bus.timer_clr);
        end
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        total++;
        if ({bus.state, bus.timer_en, bus.timer_clr} !== {2'd1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL resume: got st=%0d en=%b clr=%b expected st=1 en=1 clr=0", bus.state, bus.timer_en, bus.timer_clr);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_timeup_alarm();
        logic exp_alarm;
        // time_up together with pause and a tick: DONE wins, entry tick not counted
        step(0, 1, 0, 1, 1);
        total++;
        if ({bus.state, bus.done, bus.timer_en, bus.alarm} !== {2'd3, 1'b1, 1'b0, 1'b1}) begin
            bad++; $display("FAIL timeup_entry: got st=%0d done=%b en=%b alarm=%b expected st=3 done=1 en=0 alarm=1",
                            bus.state, bus.done, bus.timer_en, bus.alarm);
        end
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, 1);
            step(0, 0, 0, 1, 1);
            exp_alarm = (i < ALARM_TICKS);
            total++;
            if (bus.alarm !== exp_alarm || bus.state !== 2'd3) begin
                bad++; $display("FAIL alarm_tick%0d: got alarm=%b st=%0d expected alarm=%b st=3", i, bus.alarm, bus.state, exp_alarm);
            end
        end
    endtask

    task automatic test_done_restart();
        step(1, 0, 0, 0, 0);
        total++;
        if ({bus.state, bus.timer_clr} !== {2'd1, 1'b1}) begin
            bad++; $display("FAIL done_restart: got st=%0d clr=%b expected st=1 clr=1", bus.state, bus.timer_clr);
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        total++;
        if (bus.alarm !== 1'b1) begin bad++; $display("FAIL alarm_active: got %b expected 1", bus.alarm); end
        step(1, 0, 0, 0, 0);
        total++;
        if ({bus.state, bus.timer_clr, bus.alarm, bus.timer_en} !== {2'd1, 1'b1, 1'b0, 1'b1}) begin
            bad++; $display("FAIL alarm_abort: got st=%0d clr=%b alarm=%b en=%b expected st=1 clr=1 alarm=0 en=1",
                            bus.state, bus.timer_clr, bus.alarm, bus.timer_en);
        end
        step(0, 0, 0, 0, 0);
        total++;
        if (bus.timer_clr !== 1'b0) begin bad++; $display("FAIL abort_clr_width: got %b expected 0", bus.timer_clr); end
    endtask

    task automatic test_clear_priority();
        int pulses;
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        total++;
        if (bus.state !== 2'd2) begin bad++; $display("FAIL reach_pause: got %0d expected 2", bus.state); end
        pulses = 0;
        step(1, 0, 1, 0, 0);
        if (bus.timer_clr) pulses++;
        total++;
        if (bus.state !== 2'd0) begin bad++; $display("FAIL clear_wins: got st=%0d expected 0", bus.state); end
        step(1, 0, 0, 0, 0);
        if (bus.timer_clr) pulses++;
        total++;
        if (pulses != 1 || bus.state !== 2'd0) begin
            bad++; $display("FAIL clear_once: got pulses=%0d st=%0d expected pulses=1 st=0", pulses, bus.state);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        total++;
        if (bus.state !== 2'd1) begin bad++; $display("FAIL async_pre_run: got %0d expected 1", bus.state); end
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        total++;
        if (dut_vec() !== 6'b0) begin bad++; $display("FAIL async_outputs: got %b expected %b", dut_vec(), 6'b0); end
        @(negedge clk);
        rstn = 1'b1;
        step(0, 0, 0, 0, 0);
        total++;
        if (dut_vec() !== 6'b0) begin bad++; $display("FAIL async_release: got %b expected %b", dut_vec(), 6'b0); end
        // start held through reset release yields one event on the first clock
        rstn = 1'b0;
        model_reset();
        bus.btn_start = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        step(1, 0, 0, 0, 0);
        total++;
        if ({bus.state, bus.timer_clr} !== {2'd1, 1'b1}) begin
            bad++; $display("FAIL held_through_reset: got st=%0d clr=%b expected st=1 clr=1", bus.state, bus.timer_clr);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit s, p, c, t, tu;
        rstn = 1'b0;
        model_reset();
        bus.btn_start = 0; bus.btn_pause = 0; bus.btn_clear = 0;
        #3;
        rstn = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            s  = ($urandom_range(0, 5) == 0);
            p  = ($urandom_range(0, 5) == 0);
            c  = ($urandom_range(0, 40) == 0);
            t  = ($urandom_range(0, 3) == 0);
            tu = ($urandom_range(0, 15) == 0);
            step(s, p, c, t, tu);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL random_cycle%0d: got %b expected %b", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_hold();
        test_pause_resume();
        test_timeup_alarm();
        test_done_restart();
        test_clear_priority();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
